fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 83 ++++++++
 tb/tb_fetch_queue.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue: push side, head outputs and control.
interface fetch_queue_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PTR_W  = 2
);
    logic              FLUSH;
    logic              STALL;
    logic              Valid_IF;
    logic [DATA_W-1:0] Instr1_IF;
    logic [31:0]       Instr_PC_IF;
    logic [31:0]       Instr_PC_Plus4_IF;
    logic              Ready_IF;
    logic              Valid_OUT;
    logic [DATA_W-1:0] Instr1_OUT;
    logic [31:0]       Instr_PC_OUT;
    logic [31:0]       Instr_PC_Plus4;
    logic [PTR_W:0]    Count_OUT;
    logic              Overflow_OUT;

    modport master (
        output FLUSH, STALL, Valid_IF, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF,
        input  Ready_IF, Valid_OUT, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4,
               Count_OUT, Overflow_OUT
    );

    modport slave (
        input  FLUSH, STALL, Valid_IF, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF,
        output Ready_IF, Valid_OUT, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4,
               Count_OUT, Overflow_OUT
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode with flush, stall and drop reporting.
module fetch_queue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RESET,
    fetch_queue_if.slave  bus
);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [31:0]       pc;
        logic [31:0]       pc_plus4;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             ready_c, valid_c, push_c, pop_c;

    // Occupancy-derived handshake and next-state of pointers/count
    always_comb begin
        ready_c  = (count_q < DEPTH_CNT);
        valid_c  = (count_q != '0);
        push_c   = bus.Valid_IF && ready_c && !bus.FLUSH;
        pop_c    = valid_c && !bus.STALL && !bus.FLUSH;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = bus.Valid_IF && !ready_c && !bus.FLUSH;
        if (bus.FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_c && !pop_c)      count_d = count_q + (PTR_W+1)'(1);
            else if (pop_c && !push_c) count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is never reset; the output mux hides it whenever the queue is empty
    always_ff @(posedge CLK) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= '{instr: bus.Instr1_IF, pc: bus.Instr_PC_IF,
                                 pc_plus4: bus.Instr_PC_Plus4_IF};
        end
    end

    always_comb begin
        head = '0;
        if (valid_c) head = mem_q[rd_ptr_q];
    end

    assign bus.Ready_IF       = ready_c;
    assign bus.Valid_OUT      = valid_c;
    assign bus.Instr1_OUT     = head.instr;
    assign bus.Instr_PC_OUT   = head.pc;
    assign bus.Instr_PC_Plus4 = head.pc_plus4;
    assign bus.Count_OUT      = count_q;
    assign bus.Overflow_OUT   = ovf_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomized check of fetch_queue against a queue-based reference model.
module tb_fetch_queue;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;

    logic CLK;
    logic RESET;
    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    bit   exp_ovf;

    fetch_queue_if #(.DATA_W(DATA_W), .PTR_W(PTR_W)) bus ();

    fetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit st, input bit fl);
        bus.Valid_IF          = v;
        bus.Instr_PC_IF       = pc;
        bus.Instr_PC_Plus4_IF = pc + 32'd4;
        bus.Instr1_IF         = $urandom;
        bus.STALL             = st;
        bus.FLUSH             = fl;
    endtask

    task automatic check_outs(input string tag);
        ent_t h;
        h = '{instr: 32'd0, pc: 32'd0, pc4: 32'd0};
        if (q.size() != 0) h = q[0];
        chk({tag, "_cnt"},   64'(bus.Count_OUT),      64'(q.size()));
        chk({tag, "_valid"}, 64'(bus.Valid_OUT),      64'(q.size() != 0));
        chk({tag, "_ready"}, 64'(bus.Ready_IF),       64'(q.size() < DEPTH));
        chk({tag, "_instr"}, 64'(bus.Instr1_OUT),     64'(h.instr));
        chk({tag, "_pc"},    64'(bus.Instr_PC_OUT),   64'(h.pc));
        chk({tag, "_pc4"},   64'(bus.Instr_PC_Plus4), 64'(h.pc4));
        chk({tag, "_ovf"},   64'(bus.Overflow_OUT),   64'(exp_ovf));
    endtask

    // Reference behaviour at one rising edge, from the inputs currently driven
    task automatic model_edge();
        bit   can_push;
        bit   can_pop;
        ent_t e;
        can_push = q.size() < DEPTH;
        can_pop  = q.size() != 0 && !bus.STALL;
        e = '{instr: bus.Instr1_IF, pc: bus.Instr_PC_IF, pc4: bus.Instr_PC_Plus4_IF};
        if (bus.FLUSH) begin
            q.delete();
            exp_ovf = 1'b0;
        end else begin
            exp_ovf = bus.Valid_IF && !can_push;
            if (can_pop) void'(q.pop_front());
            if (bus.Valid_IF && can_push) q.push_back(e);
        end
    endtask

    task automatic cycle(input string tag);
        chk({tag, "_ready_pre"}, 64'(bus.Ready_IF), 64'(q.size() < DEPTH));
        model_edge();
        @(posedge CLK);
        #1;
        check_outs(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 RESET = 1'b1;
        q.delete();
        exp_ovf = 1'b0;
        #1 check_outs(tag);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        exp_ovf = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2 check_outs("reset");
        @(negedge CLK);
        RESET = 1'b0;

        // Stalled pushes, then release and drain in order
        drive(1'b1, 32'h100, 1'b1, 1'b0); cycle("stall_p0");
        drive(1'b1, 32'h104, 1'b1, 1'b0); cycle("stall_p1");
        drive(1'b1, 32'h108, 1'b1, 1'b0); cycle("stall_p2");
        chk("stall_cnt3", 64'(bus.Count_OUT), 64'd3);
        chk("stall_head", 64'(bus.Instr_PC_OUT), 64'h100);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("drain");
        chk("drain_empty", 64'(bus.Valid_OUT), 64'd0);

        // Fill while stalled, then a dropped push
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
            cycle("fill");
        end
        drive(1'b1, 32'h200, 1'b1, 1'b0); cycle("ovf_drop");
        chk("ovf_pulse", 64'(bus.Overflow_OUT), 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);   cycle("ovf_clear");

        // Full, unstalled, push offered: pop happens, push refused
        drive(1'b1, 32'h500, 1'b0, 1'b0); cycle("full_pop");
        chk("full_pop_cnt", 64'(bus.Count_OUT), 64'd3);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle("drain2");

        // Streaming across pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            cycle("wrap");
            chk("wrap_cnt_le1", 64'(bus.Count_OUT <= 3'd1), 64'd1);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0); cycle("wrap_tail");

        // Flush overrides stall and push
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h280 + 32'(4 * i), 1'b1, 1'b0);
            cycle("pre_flush");
        end
        drive(1'b1, 32'h300, 1'b1, 1'b1); cycle("flush");
        drive(1'b0, 32'h0, 1'b0, 1'b0);   cycle("post_flush");

        // Asynchronous reset mid-operation, then first push after release
        drive(1'b1, 32'h380, 1'b1, 1'b0); cycle("pre_rst0");
        drive(1'b1, 32'h384, 1'b1, 1'b0); cycle("pre_rst1");
        async_reset("async_rst");
        drive(1'b1, 32'h400, 1'b0, 1'b0); cycle("post_rst");
        chk("post_rst_pc", 64'(bus.Instr_PC_OUT), 64'h400);
        drive(1'b0, 32'h0, 1'b0, 1'b0);   cycle("post_rst_drain");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 35,
                  $urandom_range(0, 99) < 4);
            cycle("rand");
            if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
